mask_index_decoder: RTL



---
 rtl/mask_index_pkg.sv | 21 ++
 rtl/mask_rebuild_check.sv | 46 ++++
 rtl/mask_index_decoder.sv | 115 +++++++++++
 3 files changed

// File: rtl/mask_index_pkg.sv
// Shared types and defaults for the mask-to-index decoder.
// Holds the FSM state encoding and the count-width helper.
package mask_index_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int IDX_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The count must represent WIDTH itself, hence one bit more than an index.
    function automatic int cnt_width(input int idx_w);
        return idx_w + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(IDX_W_DEF);

endpackage

// File: rtl/mask_rebuild_check.sv
// Rebuilds the mask from the emitted indices and compares it against the
// latched input mask; instantiated only when MASK_INDEX_REBUILD_EN is defined.
module mask_rebuild_check
    import mask_index_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_mask,
    input  logic             i_hs,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_check,
    output logic             o_mismatch
);

    logic [WIDTH-1:0] r_rebuild;
    logic [WIDTH-1:0] r_mask_copy;
    logic             r_mismatch;
    logic [WIDTH-1:0] w_onehot;

    assign w_onehot   = {{(WIDTH-1){1'b0}}, 1'b1} << i_idx;
    assign o_mismatch = r_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rebuild   <= '0;
            r_mask_copy <= '0;
            r_mismatch  <= 1'b0;
        end else if (i_clear) begin
            r_rebuild   <= '0;
            r_mask_copy <= i_mask;
            r_mismatch  <= 1'b0;
        end else begin
            if (i_hs) begin
                r_rebuild <= r_rebuild ^ w_onehot;
            end
            if (i_check) begin
                r_mismatch <= (r_rebuild != r_mask_copy);
            end
        end
    end

endmodule

// File: rtl/mask_index_decoder.sv
// Decodes a bitmask into its set-bit indices, one per valid/ready handshake,
// lowest first, with popcount and odd parity. Optional: MASK_INDEX_REBUILD_EN.
module mask_index_decoder
    import mask_index_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mask_in,
    output logic             busy,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx_data,
    output logic             idx_last,
    output logic             done,
    output logic [IDX_W:0]   count,
    output logic             parity,
    output logic             mismatch
);

    localparam int CNT_W = cnt_width(IDX_W);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sreg;
    logic [IDX_W-1:0] r_pos;
    logic [CNT_W-1:0] r_count;
    logic             r_parity;

    logic             w_accept;
    logic             w_handshake;
    logic             w_advance;
    logic             w_top_bit;

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_handshake = idx_valid && idx_ready;
    assign w_top_bit   = ((r_sreg >> 1) == '0);
    // Clear bits always shift; a set bit shifts only once the consumer takes it.
    assign w_advance   = (r_state == ST_SCAN) && (r_sreg != '0) &&
                         (!r_sreg[0] || idx_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (start)          w_next_state = ST_SCAN;
            ST_SCAN: if (r_sreg == '0)   w_next_state = ST_DONE;
            ST_DONE:                     w_next_state = ST_IDLE;
            default:                     w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != ST_IDLE);
        idx_valid = (r_state == ST_SCAN) && r_sreg[0];
        idx_data  = r_pos;
        idx_last  = (r_state == ST_SCAN) && r_sreg[0] && w_top_bit;
        done      = (r_state == ST_DONE);
        count     = r_count;
        parity    = r_parity;
    end

    // pos stops at the highest set bit so it never wraps past WIDTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg   <= '0;
            r_pos    <= '0;
            r_count  <= '0;
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_sreg   <= mask_in;
            r_pos    <= '0;
            r_count  <= '0;
            r_parity <= 1'b0;
        end else if (w_advance) begin
            r_sreg <= r_sreg >> 1;
            if (!w_top_bit) begin
                r_pos <= r_pos + IDX_W'(1);
            end
            if (w_handshake) begin
                r_count  <= r_count + CNT_W'(1);
                r_parity <= ~r_parity;
            end
        end
    end

`ifdef MASK_INDEX_REBUILD_EN
    mask_rebuild_check #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_rebuild_check (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_accept),
        .i_mask     (mask_in),
        .i_hs       (w_handshake),
        .i_idx      (r_pos),
        .i_check    (r_state == ST_DONE),
        .o_mismatch (mismatch)
    );
`else
    assign mismatch = 1'b0;
`endif

endmodule
